resp_collector: RTL

RESP_COLLECTOR -- requirements
Module: resp_collector

---
 rtl/resp_collector.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/resp_collector.sv
// resp_collector: gathers single-bit responses for a full sweep of NBITS-wide
// stimulus patterns into a 2**NBITS-bit word and hands it off with valid/ready.
// Out-of-order patterns raise a sticky seq_err for the current sweep.
// Optional feature: define RESP_GOLDEN_CMP_EN to add a golden-word comparison
// (golden / mismatch / mismatch_cnt ports) evaluated when the sweep completes.
module resp_collector #(
  parameter int NBITS = 5
) (
  input  logic                  CK,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [NBITS-1:0]      in_pattern,
  input  logic                  in_resp,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**NBITS)-1:0] out_word,
  output logic                  seq_err,
  output logic                  done
`ifdef RESP_GOLDEN_CMP_EN
  ,
  input  logic [(2**NBITS)-1:0] golden,
  output logic                  mismatch,
  output logic [NBITS:0]        mismatch_cnt
`endif
);

  localparam int W = 2 ** NBITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t             r_state;
  logic [W-1:0]       r_word;
  logic [NBITS-1:0]   r_expect;
  logic               r_seq_err;
  logic               r_done;
  logic               r_in_ready;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_first;
  logic               w_last;
  logic [W-1:0]       w_word_upd;

  // A sample is taken only while the collector advertises ready.
  assign w_accept = in_valid & r_in_ready;
  assign w_first  = (in_pattern == '0);
  assign w_last   = (in_pattern == {NBITS{1'b1}});

  // Current word with the incoming response dropped into its pattern slot.
  always_comb begin
    w_word_upd             = r_word;
    w_word_upd[in_pattern] = in_resp;
  end

  // Sweep FSM: IDLE waits for pattern 0, COLLECT fills the word, DRAIN holds it
  // until the consumer takes it. All outputs are registered here.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_expect    <= '0;
      r_seq_err   <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_first) begin
              // New sweep: previous word is discarded, only bit 0 is loaded.
              r_word    <= W'(in_resp);
              r_expect  <= NBITS'(1);
              r_seq_err <= 1'b0;
              r_done    <= 1'b0;
              r_state   <= COLLECT;
            end else begin
              // A sweep cannot start mid-sequence; drop the sample and flag it.
              r_seq_err <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (w_accept) begin
            // Out-of-order samples are still stored; only the flag records it.
            r_word   <= w_word_upd;
            r_expect <= in_pattern + 1'b1;
            if (in_pattern != r_expect) begin
              r_seq_err <= 1'b1;
            end
            if (w_last) begin
              r_state     <= DRAIN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Word is frozen and inputs are ignored until the handoff.
          if (out_ready) begin
            r_done      <= 1'b1;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_word  = r_word;
  assign seq_err   = r_seq_err;
  assign done      = r_done;

`ifdef RESP_GOLDEN_CMP_EN
  logic             r_mismatch;
  logic [NBITS:0]   r_mismatch_cnt;

  function automatic logic [NBITS:0] popcount(input logic [W-1:0] v);
    logic [NBITS:0] acc;
    acc = '0;
    for (int k = 0; k < W; k++) begin
      acc = acc + {{NBITS{1'b0}}, v[k]};
    end
    return acc;
  endfunction

  // Golden comparison is latched as the final word is formed and held for the sweep.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      r_mismatch     <= 1'b0;
      r_mismatch_cnt <= '0;
    end else if ((r_state == IDLE) && w_accept && w_first) begin
      r_mismatch     <= 1'b0;
      r_mismatch_cnt <= '0;
    end else if ((r_state == COLLECT) && w_accept && w_last) begin
      r_mismatch     <= (w_word_upd != golden);
      r_mismatch_cnt <= popcount(w_word_upd ^ golden);
    end
  end

  assign mismatch     = r_mismatch;
  assign mismatch_cnt = r_mismatch_cnt;
`endif

endmodule
